// File: rtl/video_to_axis.sv
// Video timing input to AXI4-Stream converter with a first-word-fall-through output FIFO.
module video_to_axis #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 4,
  parameter logic        V_POL     = 1'b1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 vid_vsync,
  input  logic                 vid_active_video,
  input  logic [DATA_BITS-1:0] vid_data,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 locked,
  output logic                 overflow
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned PTR_W = ADDR_BITS + 1;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 last;
    logic                 user;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_vs_on;
  logic                 r_pend_valid;
  logic [DATA_BITS-1:0] r_pend_data;
  logic                 r_pend_user;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic                 r_locked;
  logic                 r_overflow;
  beat_t                r_mem [DEPTH];

  logic                 w_vs_on;
  logic                 w_frame_edge;
  logic                 w_accept;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr_req;
  logic                 w_wr_en;
  logic                 w_ovf_evt;
  beat_t                w_wr_beat;
  beat_t                w_head;

  // Frame edge: vsync newly asserted relative to its registered copy.
  assign w_vs_on      = (vid_vsync == V_POL);
  assign w_frame_edge = w_vs_on & ~r_vs_on;

  // Pixels are only taken while synchronised to a frame.
  assign w_accept = vid_active_video & ((r_state == WAIT_SOF) | (r_state == ACTIVE));

  // FIFO status; the extra pointer MSB separates full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_BITS] != r_rd_ptr[ADDR_BITS]) &&
                   (r_wr_ptr[ADDR_BITS-1:0] == r_rd_ptr[ADDR_BITS-1:0]);
  assign w_pop   = ~w_empty & m_axis_tready;

  // Pending pixel is committed unless dropping; a simultaneous pop frees room when full.
  assign w_wr_req  = r_pend_valid & (r_state != DROP);
  assign w_wr_en   = w_wr_req & (~w_full | w_pop);
  assign w_ovf_evt = w_wr_req & w_full & ~w_pop;

  // Line ends when active video falls; a frame edge also closes the pending pixel.
  assign w_wr_beat.data = r_pend_data;
  assign w_wr_beat.last = ~vid_active_video | w_frame_edge;
  assign w_wr_beat.user = r_pend_user;

  // Head of the FIFO drives the stream directly.
  assign w_head        = r_mem[r_rd_ptr[ADDR_BITS-1:0]];
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tdata  = w_head.data;
  assign m_axis_tlast  = w_head.last;
  assign m_axis_tuser  = w_head.user;
  assign locked        = r_locked;
  assign overflow      = r_overflow;

  // Next-state logic; an overflow overrides every other transition.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_frame_edge) w_next_state = WAIT_SOF;
      WAIT_SOF: begin
        if (w_frame_edge)          w_next_state = WAIT_SOF;
        else if (vid_active_video) w_next_state = ACTIVE;
      end
      ACTIVE:   if (w_frame_edge) w_next_state = WAIT_SOF;
      DROP:     if (w_frame_edge) w_next_state = WAIT_SOF;
      default:  w_next_state = IDLE;
    endcase
    if (w_ovf_evt) w_next_state = DROP;
  end

  // State, sync tracking, pending stage, FIFO pointers and status flags.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_vs_on      <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_pend_user  <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_locked     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_vs_on      <= w_vs_on;
      r_pend_valid <= w_accept;
      r_pend_data  <= vid_data;
      r_pend_user  <= (r_state == WAIT_SOF);
      r_locked     <= (w_next_state == WAIT_SOF) | (w_next_state == ACTIVE);
      if (w_ovf_evt) r_overflow <= 1'b1;
      if (w_wr_en)   r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (w_wr_en) r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= w_wr_beat;
  end

endmodule

// File: tb/tb_video_to_axis.sv
// Scoreboard bench for video_to_axis: frame-level reference model feeds an expected-beat queue.
module tb_video_to_axis;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  localparam int M_OFF   = 0;  // not synchronised to any frame
  localparam int M_SEEK  = 1;  // synchronised, waiting for the first pixel
  localparam int M_FRAME = 2;  // inside a frame
  localparam int M_DROP  = 3;  // lost data, waiting for the next frame

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          vid_vsync;
  logic          vid_active_video;
  logic [DW-1:0] vid_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          locked;
  logic          overflow;

  always #5 aclk = ~aclk;

  video_to_axis #(.DATA_BITS(DW), .ADDR_BITS(AW), .V_POL(1'b1)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .vid_vsync        (vid_vsync),
    .vid_active_video (vid_active_video),
    .vid_data         (vid_data),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .locked           (locked),
    .overflow         (overflow)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   beats   = 0;
  int   rdy_pct = 100;

  // Reference model state
  bit            m_started = 1'b0;
  bit            m_vs_prev = 1'b0;
  int            m_mode    = M_OFF;
  bit            m_pend_v  = 1'b0;
  logic [DW-1:0] m_pend_d  = '0;
  bit            m_pend_u  = 1'b0;
  int            m_cnt     = 0;
  bit            m_ovf     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock of the reference model, fed the inputs present before the edge.
  task automatic model_step(input bit rn, input bit vs, input bit av, input logic [DW-1:0] d,
                            input bit rdy);
    bit edge_v, full, pop, lost, accept;
    m_started = 1'b1;
    if (!rn) begin
      m_vs_prev = 1'b0; m_mode = M_OFF; m_pend_v = 1'b0; m_cnt = 0; m_ovf = 1'b0;
      sb.delete();
      return;
    end
    edge_v = vs && !m_vs_prev;
    full   = (m_cnt == DEPTH);
    pop    = (m_cnt > 0) && rdy;
    lost   = 1'b0;
    if (m_pend_v && m_mode != M_DROP) begin
      if (!full || pop) begin
        sb.push_back('{data: m_pend_d, last: (!av) || edge_v, user: m_pend_u});
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
        lost  = 1'b1;
      end
    end
    if (pop) m_cnt--;
    accept   = (m_mode == M_SEEK || m_mode == M_FRAME) && av;
    m_pend_v = accept;
    m_pend_d = d;
    m_pend_u = (m_mode == M_SEEK);
    if (lost)                        m_mode = M_DROP;
    else if (edge_v)                 m_mode = M_SEEK;
    else if (m_mode == M_SEEK && av) m_mode = M_FRAME;
    m_vs_prev = vs;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle past it.
  task automatic tick(input bit rn, input bit vs, input bit av, input logic [DW-1:0] d);
    bit rdy;
    rdy              = ($urandom_range(99) < rdy_pct);
    aresetn          = rn;
    vid_vsync        = vs;
    vid_active_video = av;
    vid_data         = d;
    m_axis_tready    = rdy;
    @(posedge aclk);
    model_step(rn, vs, av, d, rdy);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_pulse();
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic line(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b1, base + DW'(i));
    tick(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: per-cycle flag checks and in-order beat comparison against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (m_started) begin
        chk("tvalid", 32'(m_axis_tvalid), 32'(m_cnt != 0));
        chk("locked", 32'(locked), 32'(m_mode == M_SEEK || m_mode == M_FRAME));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
          beats++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected actual data=%h last=%b user=%b expected none",
                     m_axis_tdata, m_axis_tlast, m_axis_tuser);
          end else begin
            e = sb.pop_front();
            if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== e) begin
              errors++;
              $display("FAIL beat actual data=%h last=%b user=%b expected data=%h last=%b user=%b",
                       m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
            end
          end
        end
      end
    end
  end

  initial begin
    int b0;
    bit vsr;
    aresetn = 1'b0; vid_vsync = 1'b0; vid_active_video = 1'b0; vid_data = '0;
    m_axis_tready = 1'b1;

    // Reset
    rdy_pct = 100;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Pixels before any frame edge are ignored
    b0 = beats;
    line(4, 8'h20);
    idle(3);
    chk("presync_beats", 32'(beats - b0), 32'd0);
    chk("presync_locked", 32'(locked), 32'd0);

    // Basic frame: two lines of four pixels
    b0 = beats;
    vs_pulse();
    idle(2);
    line(4, 8'h10);
    idle(2);
    line(4, 8'h14);
    chk("frame_locked", 32'(locked), 32'd1);
    idle(4);
    chk("frame_beats", 32'(beats - b0), 32'd8);

    // Frame edge right after the last pixel of a line
    b0 = beats;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 8'h30 + 8'(i));
    vs_pulse();
    idle(2);
    line(2, 8'h40);
    idle(4);
    chk("edge_after_px_beats", 32'(beats - b0), 32'd5);

    // FIFO full, then a line streamed through with tready held high
    b0 = beats;
    rdy_pct = 0;
    line(4, 8'h50);
    idle(2);
    chk("full_tvalid", 32'(m_axis_tvalid), 32'd1);
    rdy_pct = 100;
    line(4, 8'h58);
    idle(6);
    chk("full_pass_overflow", 32'(overflow), 32'd0);
    chk("full_pass_beats", 32'(beats - b0), 32'd8);

    // One-cycle reset mid-line
    tick(1'b1, 1'b0, 1'b1, 8'h61);
    tick(1'b0, 1'b0, 1'b1, 8'h62);
    chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    b0 = beats;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 8'h63 + 8'(i));
    idle(3);
    chk("midrst_beats", 32'(beats - b0), 32'd0);

    // Overflow on a six-pixel line with the stream stalled
    vs_pulse();
    rdy_pct = 0;
    line(6, 8'h60);
    idle(3);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_locked", 32'(locked), 32'd0);
    chk("ovf_tvalid", 32'(m_axis_tvalid), 32'd1);
    b0 = beats;
    rdy_pct = 100;
    idle(6);
    chk("ovf_drain_beats", 32'(beats - b0), 32'd4);
    b0 = beats;
    vs_pulse();
    idle(1);
    line(4, 8'h70);
    idle(5);
    chk("ovf_next_frame_beats", 32'(beats - b0), 32'd4);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Randomised traffic
    vsr = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) rdy_pct = $urandom_range(100);
      if ($urandom_range(99) < 4) vsr = ~vsr;
      tick($urandom_range(399) != 0, vsr, $urandom_range(99) < 60, 8'($urandom));
    end

    // Drain everything still expected
    rdy_pct = 100;
    idle(20);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_to_axis.md
VIDEO_TO_AXIS -- requirements
Module: video_to_axis

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, pixel data width.
REQ-002 SHALL have parameter ADDR_BITS, default 4, output FIFO address width; depth = 2^ADDR_BITS entries.
REQ-003 SHALL have parameter V_POL, default 1'b1, asserted level of vid_vsync.
REQ-004 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port aresetn, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port vid_vsync, input, 1, vertical sync, polarity per V_POL.
REQ-007 SHALL have port vid_active_video, input, 1, pixel-valid qualifier, active-high.
REQ-008 SHALL have port vid_data, input, DATA_BITS, pixel data, sampled when vid_active_video=1.
REQ-009 SHALL have port m_axis_tdata, output, DATA_BITS, stream pixel.
REQ-010 SHALL have port m_axis_tvalid, output, 1, stream valid.
REQ-011 SHALL have port m_axis_tready, input, 1, stream ready.
REQ-012 SHALL have port m_axis_tlast, output, 1, end-of-line marker.
REQ-013 SHALL have port m_axis_tuser, output, 1, start-of-frame marker.
REQ-014 SHALL have port locked, output, 1, high in states WAIT_SOF and ACTIVE.
REQ-015 SHALL have port overflow, output, 1, sticky FIFO-overflow flag.

Function
REQ-016 SHALL run a state machine with states IDLE, WAIT_SOF, ACTIVE, DROP.
REQ-017 SHALL define the frame edge as the cycle vid_vsync changes from not-asserted to asserted, comparing against its registered value.
REQ-018 SHALL move IDLE->WAIT_SOF and DROP->WAIT_SOF on a frame edge; otherwise hold.
REQ-019 SHALL move WAIT_SOF->ACTIVE on the first cycle vid_active_video=1; a frame edge in ACTIVE returns to WAIT_SOF.
REQ-020 SHALL accept pixels only in WAIT_SOF and ACTIVE; in IDLE and DROP pixels are discarded.
REQ-021 SHALL hold each accepted pixel in a one-stage register; it is written to the FIFO the next cycle, with tlast = NOT vid_active_video of that cycle, so tlast needs no line-length parameter.
REQ-022 SHALL set tuser=1 on the first pixel accepted in WAIT_SOF and tuser=0 on all others.
REQ-023 SHALL give 2-cycle latency: pixel sampled at edge N is written at edge N+1 and drives m_axis_tvalid=1 after edge N+1 when the FIFO was empty.
REQ-024 SHALL write the pending pixel even if a frame edge coincides with its write cycle; that pixel gets tlast=1.
REQ-025 SHALL use a first-word-fall-through FIFO: m_axis_tvalid = NOT empty; tdata/tlast/tuser = head entry, stable while tvalid=1 and tready=0.
REQ-026 SHALL pop one entry per cycle with tvalid=1 and tready=1.
REQ-027 SHALL allow write and pop in the same cycle when full, with no loss and no overflow.
REQ-028 SHALL wrap pointers modulo 2^ADDR_BITS, using an extra MSB to tell full from empty.
REQ-029 SHALL, on a write attempt when full with no pop that cycle: discard the pixel, set overflow=1, and go to DROP.
REQ-030 SHALL keep draining FIFO contents while in DROP, so the partial frame is delivered without a terminating tlast.
REQ-031 SHALL clear overflow only by reset.

Reset
REQ-032 SHALL, while aresetn=0 at a clock edge: state=IDLE, FIFO empty, pointers=0, pending register invalid, vsync register = not-asserted, m_axis_tvalid=0, locked=0, overflow=0.
REQ-033 SHALL treat reset mid-frame the same way: buffered pixels are lost, and output resumes at the first frame edge after release.

Verification
REQ-034 SHALL cover: reset, then vsync pulse, then 2 lines x 4 pixels (0x10..0x17), tready=1 -> 8 beats; tuser only on 0x10; tlast on 0x13 and 0x17; locked=1.
REQ-035 SHALL cover: active pixels before any vsync edge -> no beats, locked=0.
REQ-036 SHALL cover: ADDR_BITS=2, tready=0, one 6-pixel line -> 4 entries held, overflow=1, state DROP, locked=0; then tready=1 -> exactly 4 beats; next frame after vsync has tuser on its first pixel.
REQ-037 SHALL cover: full FIFO with tready=1 during a 4-pixel line -> no overflow, all pixels delivered in order.
REQ-038 SHALL cover: aresetn=0 for 1 cycle mid-line -> tvalid=0 the next cycle, overflow=0, no beats until after the next vsync edge.
REQ-039 SHALL cover: a vsync edge in the cycle after the last active pixel -> that pixel is delivered with tlast=1, and the next frame's first pixel has tuser=1.
